// File: rtl/ahb_burst_traffic_gen_if.sv
// AHB-Lite bus bundle between the burst traffic generator (master) and the bridge (slave).
interface ahb_burst_traffic_gen_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              Hreadyin;
    logic [DATA_W-1:0] Hrdata;
    logic [1:0]        Hresp;
    logic              Hwrite;
    logic [1:0]        Htrans;
    logic [ADDR_W-1:0] Haddr;
    logic [DATA_W-1:0] Hwdata;

    modport master (
        input  Hreadyin, Hrdata, Hresp,
        output Hwrite, Htrans, Haddr, Hwdata
    );

    modport slave (
        output Hreadyin, Hrdata, Hresp,
        input  Hwrite, Htrans, Haddr, Hwdata
    );
endinterface

// File: rtl/ahb_burst_traffic_gen.sv
// AHB-Lite master issuing an INCR write burst and/or read-back burst with data self-check.
module ahb_burst_traffic_gen #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       BURST_LEN = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000)
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_count,
    output logic              resp_err,
    ahb_burst_traffic_gen_if.master bus
);

    localparam logic [1:0]        TR_IDLE   = 2'b00;
    localparam logic [1:0]        TR_NONSEQ = 2'b10;
    localparam logic [1:0]        TR_SEQ    = 2'b11;
    localparam logic [1:0]        RESP_ERR  = 2'b01;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
    localparam logic [7:0]        LAST_IDX  = 8'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_TAIL,
        S_RD,
        S_RD_TAIL,
        S_FIN
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] seed_r;
    logic              wr_only;
    logic [7:0]        addr_idx;
    logic [7:0]        data_idx;
    logic              data_active;

    logic              addr_ok;
    logic              data_ok;
    logic              resp_error;
    logic              rd_mismatch;
    logic [DATA_W-1:0] expected;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Bus-phase qualifiers and read-data check for the beat currently in its data phase.
    always_comb begin
        addr_ok     = (bus.Htrans != TR_IDLE) && bus.Hreadyin;
        data_ok     = data_active && bus.Hreadyin;
        resp_error  = data_active && (bus.Hresp == RESP_ERR);
        expected    = seed_r + DATA_W'(data_idx);
        rd_mismatch = data_ok && ((state == S_RD) || (state == S_RD_TAIL)) &&
                      (bus.Hrdata != expected);
    end

    // Sequencer: drives address/data phases, tracks the outstanding data phase and status.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state       <= S_IDLE;
            seed_r      <= '0;
            wr_only     <= 1'b0;
            addr_idx    <= '0;
            data_idx    <= '0;
            data_active <= 1'b0;
            bus.Htrans  <= TR_IDLE;
            bus.Hwrite  <= 1'b0;
            bus.Haddr   <= '0;
            bus.Hwdata  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_count   <= '0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        seed_r      <= seed;
                        wr_only     <= (mode == 2'b01);
                        err_count   <= '0;
                        resp_err    <= 1'b0;
                        busy        <= 1'b1;
                        addr_idx    <= '0;
                        data_active <= 1'b0;
                        bus.Htrans  <= TR_NONSEQ;
                        bus.Haddr   <= BASE_ADDR;
                        bus.Hwrite  <= (mode != 2'b10);
                        state       <= (mode == 2'b10) ? S_RD : S_WR;
                    end
                end

                S_WR, S_WR_TAIL, S_RD, S_RD_TAIL: begin
                    if (resp_error) begin
                        // An ERROR response abandons everything still in flight.
                        err_count   <= sat_inc(err_count);
                        resp_err    <= 1'b1;
                        bus.Htrans  <= TR_IDLE;
                        data_active <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_FIN;
                    end else begin
                        if (rd_mismatch) begin
                            err_count <= sat_inc(err_count);
                        end
                        if (data_ok) begin
                            data_active <= 1'b0;
                        end
                        // A newly accepted address opens the next data phase, overriding the retire above.
                        if (addr_ok) begin
                            data_active <= 1'b1;
                            data_idx    <= addr_idx;
                            if (bus.Hwrite) begin
                                bus.Hwdata <= seed_r + DATA_W'(addr_idx);
                            end
                            if (addr_idx == LAST_IDX) begin
                                bus.Htrans <= TR_IDLE;
                                state      <= (state == S_WR) ? S_WR_TAIL : S_RD_TAIL;
                            end else begin
                                bus.Htrans <= TR_SEQ;
                                bus.Haddr  <= bus.Haddr + ADDR_STEP;
                                addr_idx   <= addr_idx + 8'd1;
                            end
                        end
                        if ((state == S_WR_TAIL) && data_ok) begin
                            if (wr_only) begin
                                done  <= 1'b1;
                                state <= S_FIN;
                            end else begin
                                bus.Htrans <= TR_NONSEQ;
                                bus.Haddr  <= BASE_ADDR;
                                bus.Hwrite <= 1'b0;
                                addr_idx   <= '0;
                                state      <= S_RD;
                            end
                        end
                        if ((state == S_RD_TAIL) && data_ok) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end

                S_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_burst_traffic_gen.sv
// Testbench for ahb_burst_traffic_gen: behavioural AHB slave plus transaction-level expected results.
module tb_ahb_burst_traffic_gen;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [1:0]  trans;
    } acc_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start4 = 1'b0;
    logic        start1 = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] seed = '0;
    logic        busy4, done4, re4, busy1, done1, re1;
    logic [7:0]  ec4, ec1;
    logic        s_ready = 1'b1;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_resp = 2'b00;
    bit          use1 = 1'b0;

    int checks = 0;
    int errors = 0;

    ahb_burst_traffic_gen_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();
    ahb_burst_traffic_gen_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    assign bus4.Hreadyin = s_ready;
    assign bus4.Hrdata   = s_rdata;
    assign bus4.Hresp    = s_resp;
    assign bus1.Hreadyin = s_ready;
    assign bus1.Hrdata   = s_rdata;
    assign bus1.Hresp    = s_resp;

    ahb_burst_traffic_gen #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(4), .BASE_ADDR(32'h8000_0000)) dut4 (
        .Hclk(clk), .Hreset(rst), .start(start4), .mode(mode), .seed(seed),
        .busy(busy4), .done(done4), .err_count(ec4), .resp_err(re4), .bus(bus4)
    );

    ahb_burst_traffic_gen #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(1), .BASE_ADDR(32'h8000_0000)) dut1 (
        .Hclk(clk), .Hreset(rst), .start(start1), .mode(mode), .seed(seed),
        .busy(busy1), .done(done1), .err_count(ec1), .resp_err(re1), .bus(bus1)
    );

    always #5 clk = ~clk;

    // Active DUT view.
    logic [1:0]  m_trans;
    logic [31:0] m_addr, m_wdata;
    logic        m_write, m_busy, m_done, m_re;
    logic [7:0]  m_ec;
    assign m_trans = use1 ? bus1.Htrans : bus4.Htrans;
    assign m_addr  = use1 ? bus1.Haddr  : bus4.Haddr;
    assign m_wdata = use1 ? bus1.Hwdata : bus4.Hwdata;
    assign m_write = use1 ? bus1.Hwrite : bus4.Hwrite;
    assign m_busy  = use1 ? busy1 : busy4;
    assign m_done  = use1 ? done1 : done4;
    assign m_re    = use1 ? re1 : re4;
    assign m_ec    = use1 ? ec1 : ec4;

    // Slave configuration and observed traffic.
    logic [31:0] mem [logic [31:0]];
    bit          bad_en [256];
    logic [31:0] bad_val [256];
    int          err_beat = -1;
    bit          err_write = 1'b0;
    int unsigned stall_cycles = 0;
    logic [31:0] stall_addr = '0;
    bit          stall_write = 1'b0;
    bit          stall_seen = 1'b0;
    int unsigned stall_left = 0;
    bit          rand_wait = 1'b0;
    bit          abandoned = 1'b0;
    int          post_err = 0;
    bit          dp_valid = 1'b0;
    logic [31:0] dp_addr = '0;
    bit          dp_write = 1'b0;
    logic [7:0]  dp_beat = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] snap_addr, snap_wdata;
    logic [1:0]  snap_trans;
    logic        snap_write;
    acc_t        alog[$];
    wr_t         wlog[$];

    // Expected results.
    acc_t        exp_alog[$];
    wr_t         exp_wlog[$];
    int          exp_err;
    bit          exp_resp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave: decides Hreadyin each cycle at the falling edge, so its decisions hold across the next rising edge.
    always @(negedge clk) begin
        bit rdy;
        if (rst) begin
            dp_valid   = 1'b0;
            prev_stall = 1'b0;
            stall_left = 0;
            s_ready    = 1'b1;
            s_resp     = 2'b00;
            s_rdata    = '0;
        end else begin
            s_resp  = 2'b00;
            s_rdata = '0;
            if (abandoned && m_trans != 2'b00) post_err++;
            if (prev_stall && !abandoned) begin
                chk("hold_Haddr", m_addr, snap_addr);
                chk("hold_Htrans", m_trans, snap_trans);
                chk("hold_Hwrite", m_write, snap_write);
                chk("hold_Hwdata", m_wdata, snap_wdata);
            end
            if (!stall_seen && stall_cycles != 0 && m_trans != 2'b00 &&
                m_addr == stall_addr && m_write == stall_write) begin
                stall_left = stall_cycles;
                stall_seen = 1'b1;
            end
            rdy = 1'b1;
            if (!abandoned && (dp_valid || m_trans != 2'b00)) begin
                if (stall_left != 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else if (rand_wait && $urandom_range(0, 2) == 0) begin
                    rdy = 1'b0;
                end
            end
            if (rdy && dp_valid && !abandoned) begin
                if (err_beat == int'(dp_beat) && err_write == dp_write) begin
                    s_resp    = 2'b01;
                    abandoned = 1'b1;
                    if (!dp_write) s_rdata = mem.exists(dp_addr) ? mem[dp_addr] : '0;
                end else if (dp_write) begin
                    mem[dp_addr] = m_wdata;
                    wlog.push_back('{dp_addr, m_wdata});
                end else begin
                    s_rdata = bad_en[dp_beat] ? bad_val[dp_beat] :
                              (mem.exists(dp_addr) ? mem[dp_addr] : '0);
                end
            end
            if (rdy && !abandoned) begin
                if (m_trans != 2'b00) begin
                    alog.push_back('{m_addr, m_write, m_trans});
                    dp_valid = 1'b1;
                    dp_addr  = m_addr;
                    dp_write = m_write;
                    dp_beat  = 8'((m_addr - BASE) >> 2);
                end else begin
                    dp_valid = 1'b0;
                end
            end
            prev_stall = !rdy;
            snap_addr  = m_addr;
            snap_trans = m_trans;
            snap_write = m_write;
            snap_wdata = m_wdata;
            s_ready    = rdy;
        end
    end

    // Transaction-level expectation: which addresses get issued, which writes land, final status.
    task automatic build_model(input logic [1:0] md, input logic [31:0] sd, input int unsigned bl);
        bit do_wr, do_rd, hit;
        int cnt;
        do_wr = (md != 2'b10);
        do_rd = (md != 2'b01);
        hit   = 1'b0;
        cnt   = 0;
        exp_alog.delete();
        exp_wlog.delete();
        if (do_wr) begin
            for (int unsigned i = 0; i < bl && !hit; i++) begin
                exp_alog.push_back('{BASE + 32'(4 * i), 1'b1, (i == 0) ? 2'b10 : 2'b11});
                if (err_write && err_beat == int'(i)) hit = 1'b1;
                else exp_wlog.push_back('{BASE + 32'(4 * i), sd + 32'(i)});
            end
        end
        if (do_rd && !hit) begin
            for (int unsigned i = 0; i < bl && !hit; i++) begin
                exp_alog.push_back('{BASE + 32'(4 * i), 1'b0, (i == 0) ? 2'b10 : 2'b11});
                if (!err_write && err_beat == int'(i)) hit = 1'b1;
                else if (bad_en[i]) cnt++;
            end
        end
        exp_err  = hit ? cnt + 1 : cnt;
        if (exp_err > 255) exp_err = 255;
        exp_resp = hit;
    endtask

    task automatic clear_cfg();
        for (int unsigned i = 0; i < 256; i++) begin
            bad_en[i]  = 1'b0;
            bad_val[i] = '0;
        end
        err_beat     = -1;
        err_write    = 1'b0;
        stall_cycles = 0;
        rand_wait    = 1'b0;
    endtask

    task automatic run_seq(input bit u1, input logic [1:0] md, input logic [31:0] sd,
                           input int unsigned bl, input string tag, input int poke);
        int n;
        use1 = u1;
        alog.delete();
        wlog.delete();
        abandoned  = 1'b0;
        post_err   = 0;
        stall_seen = 1'b0;
        dp_valid   = 1'b0;
        prev_stall = 1'b0;
        build_model(md, sd, bl);
        @(negedge clk);
        mode = md;
        seed = sd;
        if (u1) start1 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        chk({tag, "_busy"}, m_busy, 1'b1);
        n = 0;
        while (!m_done && n < 4000) begin
            if (n == poke) begin
                if (u1) start1 = 1'b1; else start4 = 1'b1;
                seed = ~sd;
                mode = 2'b10;
            end else begin
                start1 = 1'b0;
                start4 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start1 = 1'b0;
        start4 = 1'b0;
        chk({tag, "_done_seen"}, (n < 4000), 1'b1);
        chk({tag, "_err_count"}, m_ec, 8'(exp_err));
        chk({tag, "_resp_err"}, m_re, exp_resp);
        @(negedge clk);
        chk({tag, "_done_pulse"}, m_done, 1'b0);
        chk({tag, "_busy_clear"}, m_busy, 1'b0);
        chk({tag, "_post_err_trans"}, post_err, 0);
        chk({tag, "_n_addr"}, alog.size(), exp_alog.size());
        for (int unsigned i = 0; i < alog.size() && i < exp_alog.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), alog[i].addr, exp_alog[i].addr);
            chk($sformatf("%s_write%0d", tag, i), alog[i].write, exp_alog[i].write);
            chk($sformatf("%s_trans%0d", tag, i), alog[i].trans, exp_alog[i].trans);
        end
        chk({tag, "_n_wdata"}, wlog.size(), exp_wlog.size());
        for (int unsigned i = 0; i < wlog.size() && i < exp_wlog.size(); i++) begin
            chk($sformatf("%s_waddr%0d", tag, i), wlog[i].addr, exp_wlog[i].addr);
            chk($sformatf("%s_wdata%0d", tag, i), wlog[i].data, exp_wlog[i].data);
        end
    endtask

    task automatic chk_reset4(input string tag);
        chk({tag, "_Htrans"}, bus4.Htrans, 2'b00);
        chk({tag, "_Hwrite"}, bus4.Hwrite, 1'b0);
        chk({tag, "_Haddr"}, bus4.Haddr, 32'h0);
        chk({tag, "_Hwdata"}, bus4.Hwdata, 32'h0);
        chk({tag, "_busy"}, busy4, 1'b0);
        chk({tag, "_done"}, done4, 1'b0);
        chk({tag, "_err_count"}, ec4, 8'h00);
        chk({tag, "_resp_err"}, re4, 1'b0);
    endtask

    initial begin
        int n;
        clear_cfg();

        // Power-on reset.
        repeat (3) @(negedge clk);
        chk_reset4("rst4");
        chk("rst1_Htrans", bus1.Htrans, 2'b00);
        chk("rst1_Haddr", bus1.Haddr, 32'h0);
        chk("rst1_busy", busy1, 1'b0);
        chk("rst1_err_count", ec1, 8'h00);
        rst = 1'b0;

        // Write-then-read, zero-wait slave.
        run_seq(1'b0, 2'b00, 32'h10, 4, "t1_basic", -1);

        // Two-cycle stall on write beat 2 address.
        stall_cycles = 2;
        stall_addr   = BASE + 32'h8;
        stall_write  = 1'b1;
        run_seq(1'b0, 2'b00, 32'h1234_5678, 4, "t2_stall", -1);
        chk("t2_stall_seen", stall_seen, 1'b1);
        stall_cycles = 0;

        // Corrupted read data on beat 1.
        bad_en[1]  = 1'b1;
        bad_val[1] = 32'hDEAD;
        run_seq(1'b0, 2'b00, 32'h10, 4, "t3_baddata", -1);
        bad_en[1]  = 1'b0;

        // ERROR response on write beat 1.
        err_write = 1'b1;
        err_beat  = 1;
        run_seq(1'b0, 2'b00, 32'hA5A5_0000, 4, "t4_resp", -1);
        err_beat  = -1;
        err_write = 1'b0;

        // Start pulse while busy must be ignored.
        run_seq(1'b0, 2'b00, 32'h0000_0100, 4, "t5_poke", 3);

        // Reset in the middle of the read burst.
        use1 = 1'b0;
        alog.delete();
        wlog.delete();
        abandoned  = 1'b0;
        dp_valid   = 1'b0;
        prev_stall = 1'b0;
        bad_en[0]  = 1'b1;
        bad_val[0] = 32'hBAD0_0000;
        @(negedge clk);
        mode   = 2'b00;
        seed   = 32'h200;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!(m_trans != 2'b00 && m_write == 1'b0 && m_addr == BASE + 32'h8) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5r_reached_read", (n < 200), 1'b1);
        chk("t5r_err_before_reset", ec4, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        chk_reset4("t5r_after_reset");
        rst = 1'b0;
        bad_en[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t5r_idle_Htrans", bus4.Htrans, 2'b00);
            chk("t5r_idle_busy", busy4, 1'b0);
        end

        // Single-beat read-only burst on the BURST_LEN=1 instance.
        mem[BASE] = 32'h55;
        run_seq(1'b1, 2'b10, 32'h55, 1, "t6_bl1", -1);
        use1 = 1'b0;

        // Randomised sequences: mode, seed, wait states, corrupted beats, ERROR injection.
        for (int unsigned r = 0; r < 24; r++) begin
            logic [1:0]  md;
            logic [31:0] sd;
            md = 2'($urandom_range(0, 3));
            sd = $urandom();
            clear_cfg();
            rand_wait = 1'b1;
            for (int unsigned i = 0; i < 4; i++) begin
                bad_en[i]  = ($urandom_range(0, 3) == 0);
                bad_val[i] = (sd + 32'(i)) ^ (32'h1 << $urandom_range(0, 31));
            end
            if ($urandom_range(0, 3) == 0) begin
                err_write = ($urandom_range(0, 1) == 1);
                err_beat  = int'($urandom_range(0, 3));
                if (!err_write) bad_en[err_beat] = 1'b0;
            end
            if (md == 2'b10) begin
                for (int unsigned i = 0; i < 4; i++) mem[BASE + 32'(4 * i)] = sd + 32'(i);
            end
            run_seq(1'b0, md, sd, 4, $sformatf("rnd%0d", r), -1);
        end
        clear_cfg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_burst_traffic_gen.md
Name: ahb_burst_traffic_gen

Overview:
Parametrised, synthesizable AHB-Lite master that replaces the fixed single/burst task stimulus used at the bridge top level. On a start pulse it issues a configurable INCR burst of writes and/or reads through the AHB2APB bridge. Read data is self-checked against the written pattern. Mismatches and error responses are counted so the bridge/APB path can be soaked in simulation or on FPGA without a bench-driven master.

Parameters:
ADDR_W, 32, AHB address width
DATA_W, 32, AHB data width (byte-multiple)
BURST_LEN, 4, beats per burst (1..255)
BASE_ADDR, 32'h8000_0000, address of beat 0; beat i uses BASE_ADDR + i*(DATA_W/8)

Ports:
Hclk  in  1  system clock, all logic rising-edge
Hreset  in  1  synchronous reset, active-high
start  in  1  one-cycle request; ignored unless idle
mode  in  2  00 write-then-read, 01 write only, 10 read only, 11 treated as 00
seed  in  DATA_W  pattern seed, sampled on accepted start
Hreadyin  in  1  transfer-ready from bridge (Hreadyout)
Hrdata  in  DATA_W  read data from bridge
Hresp  in  2  response; 2'b01 = ERROR
Hwrite  out  1  AHB write/read
Htrans  out  2  00 IDLE, 10 NONSEQ, 11 SEQ
Haddr  out  ADDR_W  address phase
Hwdata  out  DATA_W  write data phase
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of sequence
err_count  out  8  saturating count of mismatches plus ERROR responses, cleared on accepted start
resp_err  out  1  sticky: an ERROR response aborted the last sequence, cleared on accepted start

Behaviour:
- Reset: Htrans=00, Hwrite=0, Haddr=0, Hwdata=0, busy=0, done=0, err_count=0, resp_err=0, FSM=IDLE. Reset mid-burst returns to IDLE next edge; no further transfers.
- States: IDLE, WR, WR_TAIL, RD, RD_TAIL, FIN.
- IDLE: start=1 latches seed and mode, clears err_count/resp_err, sets busy. Next state is WR (modes 00/01/11) or RD (mode 10). start while busy is ignored.
- Address phase accepted at a rising edge with Htrans!=00 and Hreadyin=1. Data phase completes at an edge with Hreadyin=1. Pipelined: beat i data phase overlaps beat i+1 address phase.
- While Hreadyin=0, hold Haddr, Htrans, Hwrite, Hwdata stable.
- WR: beat 0 has Htrans=10; later beats have Htrans=11; Hwrite=1. Hwdata for beat i = seed + i (mod 2^DATA_W), driven in the cycle after beat i's address is accepted.
- After the last address is accepted, go to WR_TAIL: Htrans=00. Leave when the last data phase completes.
- From WR_TAIL: mode 01 goes to FIN; otherwise go to RD.
- RD: same addressing as WR; Hwrite=0; addresses restart at BASE_ADDR. Burst latency is BURST_LEN+1 accepted cycles.
- RD_TAIL: waits for the final data phase, then goes to FIN.
- Read check: at each completing read data phase, compare Hrdata with seed + i. On mismatch, err_count increments.
- err_count saturates at 8'hFF.
- Error response: Hresp=01 seen in any data phase increments err_count and sets resp_err. Htrans is driven 00 next cycle and the FSM goes to FIN; the remainder of the sequence is abandoned.
- FIN: done=1 for one cycle, busy=0 next, return to IDLE.
- BURST_LEN=1: single NONSEQ, no SEQ beats.
- Addresses do not wrap at 1 KB; sizing BASE_ADDR is the user's responsibility.

Test Plan:
- Reset, then mode=00, seed=32'h10, BURST_LEN=4, zero-wait slave -> writes 0x10..0x13 to 0x8000_0000..0x8000_000C (NONSEQ,SEQ,SEQ,SEQ), reads back, done pulse, err_count=0.
- Slave holds Hreadyin low 2 cycles on beat 2 -> Haddr, Htrans, Hwdata held stable through the stall; totals unchanged; err_count=0.
- Slave returns 0xDEAD on read beat 1 -> err_count=1, resp_err=0, all 4 read beats still issued.
- Hresp=01 on write beat 1 -> Htrans=00 next cycle, no read phase, done pulse, err_count=1, resp_err=1.
- start re-asserted while busy, and Hreset asserted mid-read -> second start ignored; after reset, all outputs at reset values and Htrans=00.
- mode=10 with BURST_LEN=1 -> single NONSEQ read of BASE_ADDR with Hwrite=0, then done.
